maq_ajuste: RTL and testbench
=============================

MAQ_AJUSTE -- requirements
Module: maq_ajuste

Interface
REQ-001 Parameter DEBOUNCE_CYC, default 4: consecutive equal synchronized samples needed to accept a new button level.
REQ-002 Parameter REPEAT_DELAY, default 16: cycles a button must be held after its first step before auto-repeat starts.
REQ-003 Parameter REPEAT_RATE, default 4: cycles between auto-repeat steps.
REQ-004 Parameter BLINK_CYC, default 8: half-period of blink, in cycles.
REQ-005 maqh_clock  input  1  system clock; all state updates on rising edge.
REQ-006 maqh_reset  input  1  asynchronous, active-low reset.
REQ-007 btn_modo  input  1  raw mode button, active-high, asynchronous to clock, may bounce.
REQ-008 btn_mais  input  1  raw increment button, active-high, asynchronous to clock, may bounce.
REQ-009 inc_hora  output  1  hour-step strobe, one-cycle pulse.
REQ-010 inc_minuto  output  1  minute-step strobe, one-cycle pulse.
REQ-011 run_en  output  1  high only in RUN; enables the seconds timebase.
REQ-012 modo  output  2  current mode encoding (modo_t).
REQ-013 blink  output  1  display blink enable for the digit pair being set.

Function
REQ-014 Each button SHALL pass through a 2-FF synchronizer, then a debounce counter.
- Debounced level changes only after DEBOUNCE_CYC consecutive synchronized samples differ from it.
- A debounced 0->1 transition SHALL produce a one-cycle press pulse.
REQ-015 The mode FSM SHALL have states RUN, SET_HORA, SET_MIN.
- On a btn_modo press: RUN->SET_HORA->SET_MIN->RUN.
- No other transitions.
REQ-016 A btn_mais press in SET_HORA SHALL assert inc_hora and inc_minuto together for exactly one cycle, because the hour counter advances only when both strobes are high.
REQ-017 A btn_mais press in SET_MIN SHALL assert inc_minuto alone for one cycle, with inc_hora low.
REQ-018 btn_mais presses and holds in RUN SHALL be ignored; inc_hora and inc_minuto stay 0.
REQ-019 Auto-repeat:
- While debounced btn_mais stays high in a SET state, the first repeat step SHALL occur REPEAT_DELAY cycles after the initial step.
- Subsequent steps SHALL occur every REPEAT_RATE cycles.
- Repeat counters clear on release.
REQ-020 Latency: a clean raw rising edge held stable SHALL produce the step strobe on output exactly 3+DEBOUNCE_CYC clock edges after the first edge that samples it high.
REQ-021 Simultaneous modo and mais press pulses in the same cycle: the mode change wins and the mais press is discarded.
REQ-022 A mode change while btn_mais is held SHALL clear the repeat state; no further steps until btn_mais is released and pressed again.
REQ-023 run_en SHALL equal 1 iff state is RUN.
REQ-024 blink behaviour:
- In SET states, blink SHALL toggle every BLINK_CYC cycles, starting at 1 on entry to a SET state.
- In RUN, blink SHALL be 0.
REQ-025 Outputs inc_hora, inc_minuto, run_en, modo and blink SHALL all be registered.
REQ-026 Counter widths SHALL be $clog2 of the parameter plus 1 bit; no counter may wrap while a button is held.

Reset
REQ-027 Asserting maqh_reset low SHALL immediately set:
- state=RUN, run_en=1, modo=RUN
- inc_hora=0, inc_minuto=0, blink=0
- all synchronizers, debounced levels and counters cleared to 0.
REQ-028 Reset asserted mid-hold or mid-repeat SHALL abort all activity; after release, a still-held button SHALL be treated as a new press only after full debounce.

Structure
REQ-029 Package relogio_pkg SHALL hold the modo_t enum (RUN=0, SET_HORA=1, SET_MIN=2) and default parameter constants.
REQ-030 Sub-module debounce_btn SHALL hold synchronizer, debounce counter and press-pulse logic; it SHALL be instantiated twice.
REQ-031 The mode FSM, repeat timer and blink timer SHALL reside in maq_ajuste.

Verification (defaults: DEBOUNCE_CYC=4, REPEAT_DELAY=16, REPEAT_RATE=4)
REQ-032 Reset release, then three clean btn_modo presses -> modo reads SET_HORA, SET_MIN, RUN; run_en 0,0,1.
REQ-033 In SET_HORA, btn_mais high for 1 cycle only, or bounced 0/1 every 2 cycles for 20 cycles -> no strobe; clean press -> inc_hora=inc_minuto=1 for one cycle, 7 edges after the raw rise.
REQ-034 In SET_MIN, hold btn_mais 40 cycles after the first strobe -> inc_minuto pulses at offsets 0,16,20,24,28,32,36; inc_hora stays 0.
REQ-035 In RUN, hold btn_mais 50 cycles -> no strobes; both buttons rising in the same cycle while in SET_HORA -> modo=SET_MIN and no strobe.
REQ-036 Drive maqh_reset low during auto-repeat in SET_HORA with btn_mais held -> strobes stop immediately and modo=RUN; after release, no strobe (RUN).
REQ-037 Enter SET_HORA and observe 40 cycles -> blink starts at 1 and toggles every 8 cycles; entering RUN forces blink to 0.

Source files
------------

// File: rtl/relogio_pkg.sv
// Shared types and default timing constants for the clock-setting block.
package relogio_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HORA = 2'd1,
        SET_MIN  = 2'd2
    } modo_t;

    localparam int DEBOUNCE_CYC_DEF = 4;
    localparam int REPEAT_DELAY_DEF = 16;
    localparam int REPEAT_RATE_DEF  = 4;
    localparam int BLINK_CYC_DEF    = 8;

endpackage

// File: rtl/debounce_btn.sv
// Two-flop synchronizer, debounce counter and rising-edge press pulse
// for one raw push button.
module debounce_btn #(
    parameter int DEBOUNCE_CYC = 4
) (
    input  logic maqh_clock,
    input  logic maqh_reset,
    input  logic btn_raw_i,
    output logic nivel_o,
    output logic press_o
);

    localparam int CW = $clog2(DEBOUNCE_CYC) + 1;

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          nivel_q, nivel_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            nivel_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            nivel_q <= nivel_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter runs only while the synchronized sample disagrees with the
    // accepted level; any agreeing sample restarts the qualification.
    always_comb begin
        sync1_d = btn_raw_i;
        sync2_d = sync1_q;
        nivel_d = nivel_q;
        press_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q != nivel_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYC - 1)) begin
                nivel_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign nivel_o = nivel_q;
    assign press_o = press_q;

endmodule

// File: rtl/maq_ajuste.sv
// Clock-setting controller: mode FSM, hour/minute step strobes with
// auto-repeat, and blink timer for the digit pair being set.
module maq_ajuste
    import relogio_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEBOUNCE_CYC_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF,
    parameter int BLINK_CYC    = BLINK_CYC_DEF
) (
    input  logic       maqh_clock,
    input  logic       maqh_reset,
    input  logic       btn_modo,
    input  logic       btn_mais,
    output logic       inc_hora,
    output logic       inc_minuto,
    output logic       run_en,
    output logic [1:0] modo,
    output logic       blink
);

    localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ?
                          REPEAT_DELAY : REPEAT_RATE;
    localparam int RW   = $clog2(RMAX) + 1;
    localparam int BW   = $clog2(BLINK_CYC) + 1;

    logic modo_press;
    logic mais_press;
    logic mais_nivel;
    logic modo_nivel_unused;

    debounce_btn #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb_modo (
        .maqh_clock(maqh_clock),
        .maqh_reset(maqh_reset),
        .btn_raw_i (btn_modo),
        .nivel_o   (modo_nivel_unused),
        .press_o   (modo_press)
    );

    debounce_btn #(
        .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_deb_mais (
        .maqh_clock(maqh_clock),
        .maqh_reset(maqh_reset),
        .btn_raw_i (btn_mais),
        .nivel_o   (mais_nivel),
        .press_o   (mais_press)
    );

    modo_t         state_q, state_d;
    logic          inc_hora_q, inc_hora_d;
    logic          inc_min_q, inc_min_d;
    logic          run_en_q, run_en_d;
    logic          blink_q, blink_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          rep_arm_q, rep_arm_d;
    logic          rep_first_q, rep_first_d;
    logic [RW-1:0] rep_cnt_q, rep_cnt_d;
    logic [RW-1:0] rep_alvo;
    logic          step;

    always_ff @(posedge maqh_clock or negedge maqh_reset) begin
        if (!maqh_reset) begin
            state_q     <= RUN;
            inc_hora_q  <= 1'b0;
            inc_min_q   <= 1'b0;
            run_en_q    <= 1'b1;
            blink_q     <= 1'b0;
            bcnt_q      <= '0;
            rep_arm_q   <= 1'b0;
            rep_first_q <= 1'b0;
            rep_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            inc_hora_q  <= inc_hora_d;
            inc_min_q   <= inc_min_d;
            run_en_q    <= run_en_d;
            blink_q     <= blink_d;
            bcnt_q      <= bcnt_d;
            rep_arm_q   <= rep_arm_d;
            rep_first_q <= rep_first_d;
            rep_cnt_q   <= rep_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rep_arm_d   = rep_arm_q;
        rep_first_d = rep_first_q;
        rep_cnt_d   = rep_cnt_q;
        step        = 1'b0;
        rep_alvo    = rep_first_q ? RW'(REPEAT_DELAY - 1)
                                  : RW'(REPEAT_RATE - 1);

        // A mode press always wins and drops any pending repeat.
        if (modo_press) begin
            unique case (state_q)
                RUN:      state_d = SET_HORA;
                SET_HORA: state_d = SET_MIN;
                SET_MIN:  state_d = RUN;
                default:  state_d = RUN;
            endcase
            rep_arm_d = 1'b0;
            rep_cnt_d = '0;
        end else if (state_q != RUN) begin
            if (mais_press) begin
                step        = 1'b1;
                rep_arm_d   = 1'b1;
                rep_first_d = 1'b1;
                rep_cnt_d   = '0;
            end else if (rep_arm_q && mais_nivel) begin
                if (rep_cnt_q == rep_alvo) begin
                    step        = 1'b1;
                    rep_first_d = 1'b0;
                    rep_cnt_d   = '0;
                end else begin
                    rep_cnt_d = rep_cnt_q + 1'b1;
                end
            end else begin
                rep_arm_d = 1'b0;
                rep_cnt_d = '0;
            end
        end else begin
            rep_arm_d = 1'b0;
            rep_cnt_d = '0;
        end
    end

    // The hour counter downstream needs both strobes to advance.
    always_comb begin
        inc_min_d  = step;
        inc_hora_d = step && (state_q == SET_HORA);
        run_en_d   = (state_d == RUN);
    end

    always_comb begin
        blink_d = blink_q;
        bcnt_d  = bcnt_q;
        if (state_d == RUN) begin
            blink_d = 1'b0;
            bcnt_d  = '0;
        end else if (state_d != state_q) begin
            blink_d = 1'b1;
            bcnt_d  = '0;
        end else if (bcnt_q == BW'(BLINK_CYC - 1)) begin
            blink_d = ~blink_q;
            bcnt_d  = '0;
        end else begin
            bcnt_d = bcnt_q + 1'b1;
        end
    end

    assign inc_hora   = inc_hora_q;
    assign inc_minuto = inc_min_q;
    assign run_en     = run_en_q;
    assign modo       = state_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_maq_ajuste.sv
// Directed bench for maq_ajuste with default timing parameters.
module tb_maq_ajuste;

    logic       clk;
    logic       rst_n;
    logic       b_modo;
    logic       b_mais;
    logic       inc_hora;
    logic       inc_minuto;
    logic       run_en;
    logic [1:0] modo;
    logic       blink;

    int n_chk;
    int n_fail;

    maq_ajuste dut (
        .maqh_clock(clk),
        .maqh_reset(rst_n),
        .btn_modo  (b_modo),
        .btn_mais  (b_mais),
        .inc_hora  (inc_hora),
        .inc_minuto(inc_minuto),
        .run_en    (run_en),
        .modo      (modo),
        .blink     (blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic modo_press();
        b_modo = 1'b1;
        cyc(7);
    endtask

    task automatic modo_release();
        b_modo = 1'b0;
        cyc(8);
    endtask

    // Raise btn_mais and count edges until the first strobe (0 = none).
    task automatic mais_press(output int edges, output logic h,
                              output logic m);
        edges = 0;
        h = 1'b0;
        m = 1'b0;
        b_mais = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            #1;
            if (inc_hora || inc_minuto) begin
                edges = k;
                h = inc_hora;
                m = inc_minuto;
                break;
            end
        end
    endtask

    initial begin
        int   e;
        logic h;
        logic m;
        logic any;

        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        b_modo = 1'b0;
        b_mais = 1'b0;

        cyc(3);
        chk("rst_modo", 32'(modo), 32'd0);
        chk("rst_run_en", 32'(run_en), 32'd1);
        chk("rst_inc_hora", 32'(inc_hora), 32'd0);
        chk("rst_inc_min", 32'(inc_minuto), 32'd0);
        chk("rst_blink", 32'(blink), 32'd0);
        rst_n = 1'b1;
        cyc(2);

        modo_press();
        chk("m1_modo", 32'(modo), 32'd1);
        chk("m1_run_en", 32'(run_en), 32'd0);
        modo_release();
        modo_press();
        chk("m2_modo", 32'(modo), 32'd2);
        chk("m2_run_en", 32'(run_en), 32'd0);
        modo_release();
        modo_press();
        chk("m3_modo", 32'(modo), 32'd0);
        chk("m3_run_en", 32'(run_en), 32'd1);
        chk("m3_blink", 32'(blink), 32'd0);
        modo_release();

        modo_press();
        chk("bl_modo", 32'(modo), 32'd1);
        b_modo = 1'b0;
        for (int k = 0; k < 40; k++) begin
            chk($sformatf("blink_k%0d", k), 32'(blink),
                32'(((k / 8) % 2) == 0));
            cyc(1);
        end

        any = 1'b0;
        b_mais = 1'b1;
        cyc(1);
        b_mais = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc(1);
            any |= inc_hora | inc_minuto;
        end
        chk("glitch_no_strobe", 32'(any), 32'd0);

        any = 1'b0;
        for (int i = 0; i < 20; i++) begin
            b_mais = (((i >> 1) & 1) == 0);
            cyc(1);
            any |= inc_hora | inc_minuto;
        end
        b_mais = 1'b0;
        for (int k = 0; k < 10; k++) begin
            cyc(1);
            any |= inc_hora | inc_minuto;
        end
        chk("bounce_no_strobe", 32'(any), 32'd0);

        mais_press(e, h, m);
        chk("sh_latency", 32'(e), 32'd7);
        chk("sh_inc_hora", 32'(h), 32'd1);
        chk("sh_inc_min", 32'(m), 32'd1);
        b_mais = 1'b0;
        cyc(1);
        chk("sh_one_cyc_h", 32'(inc_hora), 32'd0);
        chk("sh_one_cyc_m", 32'(inc_minuto), 32'd0);
        cyc(12);

        modo_press();
        chk("smin_modo", 32'(modo), 32'd2);
        modo_release();
        mais_press(e, h, m);
        chk("sm_latency", 32'(e), 32'd7);
        chk("sm_inc_hora", 32'(h), 32'd0);
        chk("sm_inc_min", 32'(m), 32'd1);
        any = 1'b0;
        for (int k = 1; k < 40; k++) begin
            cyc(1);
            chk($sformatf("rep_k%0d", k), 32'(inc_minuto),
                32'(k >= 16 && ((k - 16) % 4) == 0));
            any |= inc_hora;
        end
        chk("rep_no_hora", 32'(any), 32'd0);
        b_mais = 1'b0;
        cyc(10);

        modo_press();
        chk("run_modo", 32'(modo), 32'd0);
        chk("run_blink", 32'(blink), 32'd0);
        chk("run_run_en", 32'(run_en), 32'd1);
        modo_release();
        any = 1'b0;
        b_mais = 1'b1;
        for (int k = 0; k < 50; k++) begin
            cyc(1);
            any |= inc_hora | inc_minuto;
        end
        chk("run_hold_no_strobe", 32'(any), 32'd0);
        b_mais = 1'b0;
        cyc(8);

        modo_press();
        modo_release();
        chk("both_pre_modo", 32'(modo), 32'd1);
        any = 1'b0;
        b_modo = 1'b1;
        b_mais = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc(1);
            any |= inc_hora | inc_minuto;
        end
        chk("both_modo", 32'(modo), 32'd2);
        chk("both_no_strobe", 32'(any), 32'd0);
        b_modo = 1'b0;
        b_mais = 1'b0;
        cyc(8);

        modo_press();
        modo_release();
        modo_press();
        modo_release();
        chk("rr_modo", 32'(modo), 32'd1);
        mais_press(e, h, m);
        chk("rr_latency", 32'(e), 32'd7);
        cyc(16);
        chk("rr_rep_hora", 32'(inc_hora), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rr_rst_hora", 32'(inc_hora), 32'd0);
        chk("rr_rst_min", 32'(inc_minuto), 32'd0);
        chk("rr_rst_modo", 32'(modo), 32'd0);
        cyc(2);
        rst_n = 1'b1;
        any = 1'b0;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            any |= inc_hora | inc_minuto;
        end
        chk("rr_post_no_strobe", 32'(any), 32'd0);
        chk("rr_post_modo", 32'(modo), 32'd0);
        chk("rr_post_run_en", 32'(run_en), 32'd1);
        b_mais = 1'b0;
        cyc(8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
